// File: rtl/mpsoc_sysid_pkg.sv
// rtl/mpsoc_sysid_pkg.sv - shared types and constants for the sysid arbiter
// Purpose: FSM state encoding, sysid slave word addresses and data width.
// Ports: none (package).
package mpsoc_sysid_pkg;

    localparam int DATA_W = 32;

    // Word addresses inside the sysid slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        BOOT_ID,
        BOOT_TS,
        IDLE,
        RESP
    } sysid_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first requester after last_grant, wrapping modulo N.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the previous winner (lowest priority this round)
//   grant      - one-hot winner, all zero when nobody requests
//   grant_idx  - index of the winner, zero when nobody requests
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int cand;

    // Walk offsets from farthest (last_grant itself) to nearest; the nearest
    // requester overwrites earlier hits, so it wins without a found flag.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        for (int i = N; i >= 1; i--) begin
            cand = int'(last_grant) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[IDX_W'(cand)]) begin
                grant                = '0;
                grant[IDX_W'(cand)]  = 1'b1;
                grant_idx            = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mpsoc_sysid_arbiter.sv
// rtl/mpsoc_sysid_arbiter.sv - boot self-check and round-robin share of the sysid slave
// Purpose: after reset reads ID and timestamp words and checks them, then
//          serves one master read at a time in round-robin order.
// Ports:
//   clock, reset              - system clock, synchronous active-high reset
//   m_read, m_address         - per-master read request and word address
//   m_waitrequest, m_readdata - per-master wait (low one cycle on completion), shared data
//   s_address, s_readdata     - sysid slave address (registered) and combinational data
//   boot_done, id_ok, id_mismatch - sticky self-check result flags
//   proto_err                 - pulse when a granted master drops its request
module mpsoc_sysid_arbiter
    import mpsoc_sysid_pkg::*;
#(
    parameter int                NUM_MASTERS = 4,
    parameter logic [DATA_W-1:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXPECTED_TS = 32'd1766662155,
    parameter bit                CHECK_TS    = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_read,
    input  logic [NUM_MASTERS-1:0] m_address,
    output logic [NUM_MASTERS-1:0] m_waitrequest,
    output logic [DATA_W-1:0]      m_readdata,
    output logic                   s_address,
    input  logic [DATA_W-1:0]      s_readdata,
    output logic                   boot_done,
    output logic                   id_ok,
    output logic                   id_mismatch,
    output logic                   proto_err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    sysid_state_e     state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             s_address_q, s_address_d;
    logic             id_pass_q, id_pass_d;
    logic             boot_done_q, boot_done_d;
    logic             id_ok_q, id_ok_d;
    logic             id_mismatch_q, id_mismatch_d;
    logic             ts_pass;

    logic [NUM_MASTERS-1:0] arb_grant;
    logic [IDX_W-1:0]       arb_idx;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req        (m_read),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        s_address_d   = s_address_q;
        id_pass_d     = id_pass_q;
        boot_done_d   = boot_done_q;
        id_ok_d       = id_ok_q;
        id_mismatch_d = id_mismatch_q;
        ts_pass       = 1'b0;
        case (state_q)
            BOOT_ID: begin
                id_pass_d   = (s_readdata == EXPECTED_ID);
                s_address_d = SYSID_ADDR_TS;
                state_d     = BOOT_TS;
            end
            BOOT_TS: begin
                ts_pass       = (s_readdata == EXPECTED_TS) || !CHECK_TS;
                boot_done_d   = 1'b1;
                id_ok_d       = id_pass_q && ts_pass;
                id_mismatch_d = !(id_pass_q && ts_pass);
                state_d       = IDLE;
            end
            IDLE: begin
                if (|arb_grant) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    s_address_d  = m_address[arb_idx];
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = BOOT_ID;
            end
        endcase
    end

    // Completion is decided in the RESP cycle itself from the live request;
    // reset suppresses it so an interrupted transfer never completes.
    always_comb begin
        m_waitrequest = '1;
        proto_err     = 1'b0;
        if (!reset && state_q == RESP) begin
            if (m_read[grant_q]) begin
                m_waitrequest[grant_q] = 1'b0;
            end else begin
                proto_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT_ID;
            last_grant_q  <= IDX_W'(NUM_MASTERS - 1);
            grant_q       <= '0;
            s_address_q   <= SYSID_ADDR_ID;
            id_pass_q     <= 1'b0;
            boot_done_q   <= 1'b0;
            id_ok_q       <= 1'b0;
            id_mismatch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            s_address_q   <= s_address_d;
            id_pass_q     <= id_pass_d;
            boot_done_q   <= boot_done_d;
            id_ok_q       <= id_ok_d;
            id_mismatch_q <= id_mismatch_d;
        end
    end

    assign m_readdata  = s_readdata;
    assign s_address   = s_address_q;
    assign boot_done   = boot_done_q;
    assign id_ok       = id_ok_q;
    assign id_mismatch = id_mismatch_q;

endmodule
